// File: rtl/mac_idle_mon_if.sv
// Control/status bundle of the MAC idle monitor: configuration and raw activity in,
// idle/wakeup status out. Valid/ready does not apply; every signal is sampled on each rx_clk edge.
interface mac_idle_mon_if #(
    parameter int N_CH  = 6,
    parameter int CNT_W = 32,
    parameter int PS_W  = 8
);
    logic [N_CH-1:0]  act_in;
    logic             mon_en;
    logic [N_CH-1:0]  ch_mask;
    logic             mode_level;
    logic [CNT_W-1:0] idle_thresh;
    logic [PS_W-1:0]  prescale;
    logic             int_clr;

    logic             idle_int;
    logic             idle_state;
    logic             wakeup;
    logic [N_CH-1:0]  wake_src;
    logic [CNT_W-1:0] idle_cnt;
    logic [1:0]       dbg_state;

    modport master (
        output act_in, mon_en, ch_mask, mode_level, idle_thresh, prescale, int_clr,
        input  idle_int, idle_state, wakeup, wake_src, idle_cnt, dbg_state
    );

    modport slave (
        input  act_in, mon_en, ch_mask, mode_level, idle_thresh, prescale, int_clr,
        output idle_int, idle_state, wakeup, wake_src, idle_cnt, dbg_state
    );
endinterface

// File: rtl/mac_idle_mon.sv
// Line-interface idle monitor: counts prescaled ticks without activity, raises a sticky
// idle interrupt at the threshold and reports which channels woke the link up.
module mac_idle_mon #(
    parameter int N_CH        = 6,
    parameter int CNT_W       = 32,
    parameter int PS_W        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           rx_clk,
    input  logic           n_hreset,
    mac_idle_mon_if.slave  bus
);
    typedef enum logic [1:0] {S_OFF, S_ACTIVE, S_COUNT, S_IDLE} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] thr_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [PS_W-1:0]  ps_q;
    logic             idle_int_q;
    logic             idle_state_q;
    logic             wakeup_q;
    logic [N_CH-1:0]  wake_src_q;
    logic [N_CH-1:0]  act_s;
    logic [N_CH-1:0]  act_d;
    logic [N_CH-1:0]  act_vec;
    logic             any_act;
    logic             tick;
    logic             thr_chg;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign act_s = bus.act_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
            always_ff @(posedge rx_clk or negedge n_hreset) begin
                if (!n_hreset) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= bus.act_in;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign act_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign act_vec = bus.mode_level ? (act_s & bus.ch_mask) : (act_s & ~act_d & bus.ch_mask);
    assign any_act = |act_vec;
    assign tick    = (ps_q == bus.prescale);
    assign thr_chg = (bus.idle_thresh != thr_q);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge rx_clk or negedge n_hreset) begin
        if (!n_hreset) begin
            state_q      <= S_OFF;
            cnt_q        <= '0;
            ps_q         <= '0;
            thr_q        <= '1;
            act_d        <= '0;
            idle_int_q   <= 1'b0;
            idle_state_q <= 1'b0;
            wakeup_q     <= 1'b0;
            wake_src_q   <= '0;
        end else begin
            thr_q    <= bus.idle_thresh;
            act_d    <= act_s;
            wakeup_q <= 1'b0;
            // A threshold-hit set later in this block overrides the clear.
            if (bus.int_clr) idle_int_q <= 1'b0;
            if (!bus.mon_en) begin
                state_q      <= S_OFF;
                cnt_q        <= '0;
                ps_q         <= '0;
                idle_state_q <= 1'b0;
            end else begin
                case (state_q)
                    S_OFF: begin
                        state_q <= S_ACTIVE;
                        cnt_q   <= '0;
                        ps_q    <= '0;
                    end
                    S_ACTIVE: begin
                        cnt_q <= '0;
                        ps_q  <= '0;
                        if (!any_act) state_q <= S_COUNT;
                    end
                    S_COUNT: begin
                        if (any_act) begin
                            state_q <= S_ACTIVE;
                            cnt_q   <= '0;
                            ps_q    <= '0;
                        end else if (thr_chg) begin
                            cnt_q <= '0;
                            ps_q  <= '0;
                        end else if (tick) begin
                            ps_q  <= '0;
                            cnt_q <= cnt_inc;
                            if (bus.idle_thresh != '0 && cnt_inc == bus.idle_thresh) begin
                                state_q      <= S_IDLE;
                                idle_state_q <= 1'b1;
                                idle_int_q   <= 1'b1;
                            end
                        end else begin
                            ps_q <= ps_q + PS_W'(1);
                        end
                    end
                    S_IDLE: begin
                        if (any_act) begin
                            state_q      <= S_ACTIVE;
                            idle_state_q <= 1'b0;
                            wakeup_q     <= 1'b1;
                            wake_src_q   <= act_vec;
                            cnt_q        <= '0;
                            ps_q         <= '0;
                        end else if (thr_chg) begin
                            state_q      <= S_COUNT;
                            idle_state_q <= 1'b0;
                            cnt_q        <= '0;
                            ps_q         <= '0;
                        end
                    end
                    default: state_q <= S_OFF;
                endcase
            end
        end
    end

    assign bus.idle_int   = idle_int_q;
    assign bus.idle_state = idle_state_q;
    assign bus.wakeup     = wakeup_q;
    assign bus.wake_src   = wake_src_q;
    assign bus.idle_cnt   = cnt_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_mac_idle_mon.sv
// Random-stimulus bench for mac_idle_mon: a behavioural model predicts the outputs after
// each rx_clk edge into a queue, and a monitor compares them against the DUT.
module tb_mac_idle_mon;
    localparam int N_CH = 6;
    localparam int CNT_W = 8;
    localparam int PS_W = 4;
    localparam int SYNC = 2;
    localparam int W = 3 + N_CH + CNT_W;

    logic clk = 1'b1;
    logic n_hreset;
    always #5 clk = ~clk;

    mac_idle_mon_if #(.N_CH(N_CH), .CNT_W(CNT_W), .PS_W(PS_W)) bus ();

    mac_idle_mon #(.N_CH(N_CH), .CNT_W(CNT_W), .PS_W(PS_W), .SYNC_STAGES(SYNC)) u_dut (
        .rx_clk   (clk),
        .n_hreset (n_hreset),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_pass = 0;
    logic [W-1:0] exp_q[$];

    // stimulus registers
    logic             r_rst, r_en, r_lvl, r_clr;
    logic [N_CH-1:0]  r_act, r_mask;
    logic [CNT_W-1:0] r_thr;
    logic [PS_W-1:0]  r_ps;

    // model state
    typedef enum int {M_OFF, M_ACTIVE, M_COUNT, M_IDLE} mphase_e;
    mphase_e          m_phase;
    int               m_cnt, m_ps;
    bit               m_int, m_wk;
    logic [N_CH-1:0]  m_src;
    logic [CNT_W-1:0] m_thr;
    logic [N_CH-1:0]  m_hist[SYNC];
    logic [N_CH-1:0]  m_prev;

    task automatic apply();
        n_hreset        = r_rst;
        bus.act_in      = r_act;
        bus.mon_en      = r_en;
        bus.ch_mask     = r_mask;
        bus.mode_level  = r_lvl;
        bus.idle_thresh = r_thr;
        bus.prescale    = r_ps;
        bus.int_clr     = r_clr;
    endtask

    // Predicts the outputs visible after the coming edge from the inputs applied now.
    task automatic model_step();
        logic [N_CH-1:0] seen, hits;
        bit any, chg;
        if (!r_rst) begin
            m_phase = M_OFF; m_cnt = 0; m_ps = 0; m_int = 0; m_wk = 0; m_src = '0;
            m_thr = '1; m_prev = '0;
            for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
        end else begin
            seen = m_hist[SYNC-1];
            hits = r_lvl ? (seen & r_mask) : (seen & ~m_prev & r_mask);
            any  = (hits != 0);
            chg  = (r_thr != m_thr);
            m_wk = 0;
            if (r_clr) m_int = 0;
            if (!r_en) begin
                m_phase = M_OFF; m_cnt = 0; m_ps = 0;
            end else if (m_phase == M_OFF) begin
                m_phase = M_ACTIVE; m_cnt = 0; m_ps = 0;
            end else if (m_phase == M_ACTIVE) begin
                if (!any) m_phase = M_COUNT;
                m_cnt = 0; m_ps = 0;
            end else if (any) begin
                if (m_phase == M_IDLE) begin
                    m_wk = 1; m_src = hits;
                end
                m_phase = M_ACTIVE; m_cnt = 0; m_ps = 0;
            end else if (chg) begin
                m_phase = M_COUNT; m_cnt = 0; m_ps = 0;
            end else if (m_phase == M_COUNT) begin
                if (m_ps == int'(r_ps)) begin
                    m_ps = 0;
                    m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
                    if (r_thr != 0 && m_cnt == int'(r_thr)) begin
                        m_phase = M_IDLE; m_int = 1;
                    end
                end else begin
                    m_ps = m_ps + 1;
                end
            end
            m_thr  = r_thr;
            m_prev = seen;
            for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = r_act;
        end
        exp_q.push_back({m_int, (m_phase == M_IDLE), m_wk, m_src, CNT_W'(m_cnt)});
    endtask

    task automatic step();
        @(negedge clk);
        apply();
        model_step();
    endtask

    task automatic reset_pulse();
        logic [W-1:0] got;
        r_rst = 1'b0;
        @(negedge clk);
        apply();
        model_step();
        #1;
        got = {bus.idle_int, bus.idle_state, bus.wakeup, bus.wake_src, bus.idle_cnt};
        n_checks++;
        if (got !== '0) $display("FAIL async_reset: got %h expected 0", got);
        else n_pass++;
        step();
        r_rst = 1'b1;
    endtask

    // monitor: one expected entry per clock edge
    initial begin
        logic [W-1:0] got, exp;
        forever begin
            @(posedge clk);
            #1;
            got = {bus.idle_int, bus.idle_state, bus.wakeup, bus.wake_src, bus.idle_cnt};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL queue_underflow: got %h with no expected entry", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp)
                    $display("FAIL outputs @%0t: got int=%0b idle=%0b wk=%0b src=%h cnt=%0d expected int=%0b idle=%0b wk=%0b src=%h cnt=%0d",
                             $time, got[W-1], got[W-2], got[W-3], got[CNT_W +: N_CH], got[CNT_W-1:0],
                             exp[W-1], exp[W-2], exp[W-3], exp[CNT_W +: N_CH], exp[CNT_W-1:0]);
                else n_pass++;
            end
        end
    end

    initial begin
        int kind, len;
        r_rst = 0; r_en = 0; r_lvl = 1; r_clr = 0; r_act = '0; r_mask = '1;
        r_thr = 8'd5; r_ps = '0;
        apply();
        repeat (3) step();
        r_rst = 1; r_en = 1;
        r_act = '1;
        repeat (4) step();
        r_act = '0;
        repeat (12) step();
        r_thr = '0;
        repeat (270) step();
        r_thr = 8'd3;
        for (int seg = 0; seg < 120; seg++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2: begin
                    r_act = '0;
                    len = $urandom_range(5, 40);
                    repeat (len) begin
                        r_clr = ($urandom_range(0, 7) == 0);
                        step();
                    end
                end
                3: begin
                    len = $urandom_range(1, 5);
                    repeat (len) begin
                        r_act = N_CH'($urandom);
                        step();
                    end
                end
                4: begin
                    r_act = r_act | (N_CH'(1) << $urandom_range(0, N_CH - 1));
                    repeat (3) step();
                end
                5: begin
                    r_lvl  = 1'($urandom_range(0, 1));
                    r_ps   = PS_W'($urandom_range(0, 3));
                    r_mask = ($urandom_range(0, 3) == 0) ? '0 :
                             (($urandom_range(0, 1) == 0) ? '1 : N_CH'($urandom));
                    step();
                end
                6: begin
                    r_thr = CNT_W'($urandom_range(0, 8));
                    step();
                end
                7: begin
                    r_en = 0;
                    repeat ($urandom_range(1, 3)) step();
                    r_en = 1;
                    step();
                end
                8: reset_pulse();
                default: begin
                    r_clr = 1;
                    step();
                end
            endcase
            r_clr = 0;
        end
        r_act = '0;
        repeat (5) step();
        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
